// File: rtl/fp_normalize_round.sv
// Normalize/round/pack stage for binary32 results from the add/sub core; one operation in flight.
// Optional IEEE exception flags {OF,UF,NX} are built only when FP_FLAGS_EN is defined.
module fp_normalize_round #(
   parameter int FRACTION = 23,
   parameter int EXPONENT = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_sign,
   input  logic [EXPONENT+1:0]          in_exp,
   input  logic [FRACTION+4:0]          in_mant,
   output logic                         out_valid,
   input  logic                         out_ready,
`ifdef FP_FLAGS_EN
   output logic [2:0]                   out_flags,
`endif
   output logic [EXPONENT+FRACTION:0]   out_result
);

   localparam int MW = FRACTION + 5;
   localparam int EW = EXPONENT + 2;
   localparam int RW = 1 + EXPONENT + FRACTION;

   localparam logic signed [EW-1:0] EXP_ONE = {{(EW-1){1'b0}}, 1'b1};
   localparam logic signed [EW-1:0] EXP_INF = {2'b00, {EXPONENT{1'b1}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Right shift by one, folding both low bits into the sticky position.
   function automatic logic [MW-1:0] shrSticky(input logic [MW-1:0] m);
      return {1'b0, m[MW-1:2], m[1] | m[0]};
   endfunction

   // Round-to-nearest-even increment decision.
   function automatic logic rneUp(input logic g, input logic r, input logic s, input logic lsb);
      return g & (r | s | lsb);
   endfunction

   state_t                 state_r;
   logic                   sign_r;
   logic signed [EW-1:0]   exp_r;
   logic [MW-1:0]          mant_r;
   logic                   outValid_r;
   logic [RW-1:0]          outResult_r;

   logic                   roundUp_s;
   logic [MW-4:0]          sum_s;
   logic [MW-5:0]          roundMant_s;
   logic signed [EW-1:0]   roundExp_s;
   logic                   inf_s;
   logic [RW-1:0]          packed_s;
`ifdef FP_FLAGS_EN
   logic [2:0]             outFlags_r;
   logic                   inexact_s;
   logic [2:0]             flags_s;
`endif

   // Rounding, post-round renormalization and packing of the held operand.
   always_comb begin
      roundUp_s = rneUp(mant_r[2], mant_r[1], mant_r[0], mant_r[3]);
      sum_s     = {1'b0, mant_r[MW-2:3]} + {{(MW-4){1'b0}}, roundUp_s};
      if (sum_s[MW-4]) begin
         roundMant_s = sum_s[MW-4:1];
         roundExp_s  = exp_r + EXP_ONE;
      end else begin
         roundMant_s = sum_s[MW-5:0];
         roundExp_s  = exp_r;
      end
      inf_s = (roundExp_s >= EXP_INF);
      if (inf_s) begin
         packed_s = {sign_r, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
      end else if (!roundMant_s[MW-5]) begin
         packed_s = {sign_r, {EXPONENT{1'b0}}, roundMant_s[FRACTION-1:0]};
      end else begin
         packed_s = {sign_r, roundExp_s[EXPONENT-1:0], roundMant_s[FRACTION-1:0]};
      end
`ifdef FP_FLAGS_EN
      inexact_s = (|mant_r[2:0]) | inf_s;
      flags_s   = {inf_s, inexact_s & (packed_s[RW-2:FRACTION] == {EXPONENT{1'b0}}), inexact_s};
`endif
   end

   // Control FSM with the datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         sign_r      <= 1'b0;
         exp_r       <= {EW{1'b0}};
         mant_r      <= {MW{1'b0}};
         outValid_r  <= 1'b0;
         outResult_r <= {RW{1'b0}};
`ifdef FP_FLAGS_EN
         outFlags_r  <= 3'b000;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  sign_r <= in_sign;
                  exp_r  <= in_exp;
                  mant_r <= in_mant;
                  if (in_mant == {MW{1'b0}}) begin
                     outResult_r <= {in_sign, {(RW-1){1'b0}}};
                     outValid_r  <= 1'b1;
`ifdef FP_FLAGS_EN
                     outFlags_r  <= 3'b000;
`endif
                     state_r     <= DONE;
                  end else begin
                     state_r <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (mant_r[MW-1]) begin
                  mant_r  <= shrSticky(mant_r);
                  exp_r   <= exp_r + EXP_ONE;
                  state_r <= ROUND;
               end else if (exp_r < EXP_ONE) begin
                  // Once only sticky content remains, further shifts cannot change it: jump to exp=1.
                  if (mant_r[MW-1:1] == {(MW-1){1'b0}}) begin
                     mant_r <= {{(MW-1){1'b0}}, |mant_r};
                     exp_r  <= EXP_ONE;
                  end else begin
                     mant_r <= shrSticky(mant_r);
                     exp_r  <= exp_r + EXP_ONE;
                  end
               end else if (!mant_r[MW-2] && (exp_r > EXP_ONE)) begin
                  mant_r <= {mant_r[MW-2:0], 1'b0};
                  exp_r  <= exp_r - EXP_ONE;
               end else begin
                  state_r <= ROUND;
               end
            end
            ROUND: begin
               outResult_r <= packed_s;
               outValid_r  <= 1'b1;
`ifdef FP_FLAGS_EN
               outFlags_r  <= flags_s;
`endif
               state_r     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  outValid_r <= 1'b0;
                  state_r    <= IDLE;
               end
            end
            default: begin
               outValid_r <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

   assign in_ready   = (state_r == IDLE);
   assign out_valid  = outValid_r;
   assign out_result = outResult_r;
`ifdef FP_FLAGS_EN
   assign out_flags  = outFlags_r;
`endif

endmodule
